multi_zskip_param: RTL and testbench

//  Parametrised sequential shift-add multiplier with zero-skipping: one add cycle per set bit of the

---
 rtl/multi_zskip_param.sv | 116 +++++++++++
 tb/tb_multi_zskip_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_zskip_param.sv
// Zero-skipping shift-add multiplier: one add per set bit of |mlier|, valid k+2 cycles after accept.
// start is accepted only while busy is low (including the valid cycle); prodt holds until the next valid.
module multi_zskip_param #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     mlier,
    input  logic [WIDTH-1:0]     mcand,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   prodt
);

    localparam int PW = 2 * WIDTH;
    localparam int IW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    prodt_q, prodt_d;
    logic             valid_q, valid_d;

    logic             smode;
    logic [WIDTH-1:0] mlier_mag;
    logic [WIDTH-1:0] mcand_mag;
    logic [IW-1:0]    idx;
    logic [PW-1:0]    addend;

    assign smode     = signed_mode & SIGNED;
    // -2^(W-1) negates to itself, which read unsigned is exactly its magnitude
    assign mlier_mag = (smode && mlier[WIDTH-1]) ? (~mlier + WIDTH'(1)) : mlier;
    assign mcand_mag = (smode && mcand[WIDTH-1]) ? (~mcand + WIDTH'(1)) : mcand;

    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (q_q[i]) begin
                idx = IW'(i);
            end
        end
    end

    assign addend = {{WIDTH{1'b0}}, h_q} << idx;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        h_d     = h_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        prodt_d = prodt_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d     = mlier_mag;
                    h_d     = mcand_mag;
                    neg_d   = smode & (mlier[WIDTH-1] ^ mcand[WIDTH-1]);
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (q_q != '0) begin
                    acc_d = acc_q + addend;
                    q_d   = q_q & ~(WIDTH'(1) << idx);
                end else begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                prodt_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            h_q     <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            prodt_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            h_q     <= h_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            prodt_q <= prodt_d;
            valid_q <= valid_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign valid = valid_q;
    assign prodt = prodt_q;

endmodule

// File: tb/tb_multi_zskip_param.sv
// Directed vector table plus hand sequences and a short random sweep for multi_zskip_param at W=32 and W=8.
module tb_multi_zskip_param;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        start32 = 1'b0, sm32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, valid32;
    logic [63:0] prodt32;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, valid8;
    logic [15:0] prodt8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    multi_zskip_param #(.WIDTH(32), .SIGNED(1'b1)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .signed_mode(sm32),
        .mlier(a32), .mcand(b32), .busy(busy32), .valid(valid32), .prodt(prodt32)
    );

    multi_zskip_param #(.WIDTH(8), .SIGNED(1'b1)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .signed_mode(sm8),
        .mlier(a8), .mcand(b8), .busy(busy8), .valid(valid8), .prodt(prodt8)
    );

    typedef struct {
        string       nm;
        bit          w8;
        bit          sm;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Counts edges until the selected DUT pulses valid; caller sits at posedge+1
    task automatic wait_valid(input bit w8, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 80) begin
            @(posedge clock); #1;
            lat++;
            got = w8 ? valid8 : valid32;
        end
    endtask

    task automatic run_op(input bit w8, input bit sm, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] ep, input int elat, input string nm);
        int lat;
        bit got;
        if (w8) begin
            start8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = 1'b1; sm32 = sm; a32 = a; b32 = b;
        end
        @(posedge clock); #1;
        start8  = 1'b0;
        start32 = 1'b0;
        wait_valid(w8, lat, got);
        check({nm, " valid seen"}, 64'(got), 64'd1);
        check({nm, " prodt"}, w8 ? {48'b0, prodt8} : prodt32, ep);
        check({nm, " latency"}, 64'(lat), 64'(elat));
        check({nm, " busy low at valid"}, 64'(w8 ? busy8 : busy32), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        bit          got;
        int          seen;
        logic [31:0] ra, rb, mag;
        logic [63:0] ep;
        bit          rsm;

        vecs[0]  = '{"u32 5x3",          1'b0, 1'b0, 32'h0000_0005, 32'h0000_0003, 64'd15, 4};
        vecs[1]  = '{"s32 -7x6",         1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6, 5};
        vecs[2]  = '{"s32 0xDEADBEEF",   1'b0, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 64'd0, 2};
        vecs[3]  = '{"u32 max x max",    1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 34};
        vecs[4]  = '{"s32 min x min",    1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 3};
        vecs[5]  = '{"s32 6x-7",         1'b0, 1'b1, 32'h0000_0006, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, 4};
        vecs[6]  = '{"s32 -1x-1",        1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 3};
        vecs[7]  = '{"u32 FFFFFFF9x6",   1'b0, 1'b0, 32'hFFFF_FFF9, 32'h0000_0006, 64'h0000_0005_FFFF_FFD6, 32};
        vecs[8]  = '{"s32 -3x0",         1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0000, 64'd0, 4};
        vecs[9]  = '{"s32 maxpos x min", 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 33};
        vecs[10] = '{"s8 80x80",         1'b1, 1'b1, 32'h80, 32'h80, 64'h4000, 3};
        vecs[11] = '{"u8 FFxFF",         1'b1, 1'b0, 32'hFF, 32'hFF, 64'hFE01, 10};
        vecs[12] = '{"s8 -1x2",          1'b1, 1'b1, 32'hFF, 32'h02, 64'hFFFE, 3};
        vecs[13] = '{"s8 min x 7F",      1'b1, 1'b1, 32'h80, 32'h7F, 64'hC080, 3};
        vecs[14] = '{"u8 81x3",          1'b1, 1'b0, 32'h81, 32'h03, 64'h0183, 4};
        vecs[15] = '{"s8 3x-3",          1'b1, 1'b1, 32'h03, 32'hFD, 64'hFFF7, 4};

        repeat (3) @(posedge clock);
        #1;
        check("reset busy32", 64'(busy32), 64'd0);
        check("reset valid32", 64'(valid32), 64'd0);
        check("reset prodt32", prodt32, 64'd0);
        check("reset busy8", 64'(busy8), 64'd0);
        check("reset prodt8", {48'b0, prodt8}, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].w8, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat, vecs[i].nm);
        end

        // start held high across two operations: second accepted in the first's valid cycle
        start32 = 1'b1; sm32 = 1'b0; a32 = 32'd5; b32 = 32'd3;
        @(posedge clock); #1;
        a32 = 32'd2; b32 = 32'd9;
        check("b2b busy after accept", 64'(busy32), 64'd1);
        wait_valid(1'b0, lat, got);
        check("b2b first prodt", prodt32, 64'd15);
        check("b2b first latency", 64'(lat), 64'd4);
        @(posedge clock); #1;
        start32 = 1'b0;
        check("b2b second accepted", 64'(busy32), 64'd1);
        wait_valid(1'b0, lat, got);
        check("b2b second prodt", prodt32, 64'd18);
        check("b2b second latency", 64'(lat), 64'd3);

        // start pulsed mid-operation must not disturb it
        start32 = 1'b1; a32 = 32'hFF; b32 = 32'd2;
        @(posedge clock); #1;
        start32 = 1'b0;
        @(posedge clock); #1;
        start32 = 1'b1; a32 = 32'd3; b32 = 32'd3;
        @(posedge clock); #1;
        start32 = 1'b0;
        check("busy pulse prodt held", prodt32, 64'd18);
        wait_valid(1'b0, lat, got);
        check("busy pulse prodt", prodt32, 64'h1FE);
        check("busy pulse latency", 64'(lat + 2), 64'd10);

        // reset in cycle 3 of a 32-add operation
        start32 = 1'b1; sm32 = 1'b0; a32 = 32'hFFFF_FFFF; b32 = 32'd1;
        @(posedge clock); #1;
        start32 = 1'b0;
        repeat (2) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort busy", 64'(busy32), 64'd0);
        check("abort valid", 64'(valid32), 64'd0);
        check("abort prodt", prodt32, 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (valid32) seen++;
        end
        check("abort no late valid", 64'(seen), 64'd0);
        run_op(1'b0, 1'b0, 32'd5, 32'd3, 64'd15, 4, "after abort");

        for (int i = 0; i < 150; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rsm = 1'($urandom_range(0, 1));
            if (i % 10 == 0) ra = '0;
            if (i % 10 == 5) ra = 32'h8000_0000;
            if (rsm) ep = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
            else     ep = {32'b0, ra} * {32'b0, rb};
            mag = (rsm && ra[31]) ? (~ra + 32'd1) : ra;
            run_op(1'b0, rsm, ra, rb, ep, $countones(mag) + 2, "rand32");
        end

        for (int i = 0; i < 150; i++) begin
            ra  = {24'b0, 8'($urandom)};
            rb  = {24'b0, 8'($urandom)};
            rsm = 1'($urandom_range(0, 1));
            if (i % 10 == 0) rb = '0;
            if (i % 10 == 5) ra = 32'h80;
            if (rsm) ep = $signed({{56{ra[7]}}, ra[7:0]}) * $signed({{56{rb[7]}}, rb[7:0]});
            else     ep = {56'b0, ra[7:0]} * {56'b0, rb[7:0]};
            ep  = {48'b0, ep[15:0]};
            mag = (rsm && ra[7]) ? {24'b0, 8'(~ra[7:0] + 8'd1)} : ra;
            run_op(1'b1, rsm, ra, rb, ep, $countones(mag) + 2, "rand8");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
